// File: rtl/maxpool_frame_loader_pkg.sv
// rtl/maxpool_frame_loader_pkg.sv - shared sizes and launch-state encoding for the max-pool frame loader
package maxpool_frame_loader_pkg;

  localparam int DATAI_WIDTH  = 4;
  localparam int DATAI_HEIGHT = 4;
  localparam int BITWIDTH     = 3;
  localparam int NPIX         = DATAI_WIDTH * DATAI_HEIGHT;
  localparam int FRAME_W      = NPIX * BITWIDTH;

  // Same encoding as the pool engine's own FSM.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/maxpool_frame_bank.sv
// rtl/maxpool_frame_bank.sv - one flat frame register with indexed pixel write
module maxpool_frame_bank #(
  parameter int npix     = 16,
  parameter int bitwidth = 3,
  localparam int iw      = $clog2(npix),
  localparam int frame_w = npix * bitwidth
) (
  input  logic                clk_en,
  input  logic                reset_n,
  input  logic                we,
  input  logic [iw-1:0]       idx,
  input  logic [bitwidth-1:0] wdata,
  output logic [frame_w-1:0]  frame
);

  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      frame <= '0;
    end else if (we) begin
      frame[idx*bitwidth +: bitwidth] <= wdata;
    end
  end

endmodule

// File: rtl/maxpool_frame_loader.sv
// rtl/maxpool_frame_loader.sv - packs a raster pixel stream into ping-pong frame banks and launches the pool
module maxpool_frame_loader
  import maxpool_frame_loader_pkg::*;
#(
  parameter int datai_width  = DATAI_WIDTH,
  parameter int datai_height = DATAI_HEIGHT,
  parameter int bitwidth     = BITWIDTH,
  localparam int npix        = datai_width * datai_height,
  localparam int frame_w     = npix * bitwidth
) (
  input  logic                clk_en,
  input  logic                reset_n,
  input  logic                pix_valid,
  input  logic [bitwidth-1:0] pix_data,
  input  logic                pix_last,
  output logic                pix_ready,
  output logic [frame_w-1:0]  frame_o,
  output logic                work_en,
  input  logic                work_fin,
  output logic                busy,
  output logic                err_len
);

  localparam int cw = $clog2(npix);

  state_t             state, state_d;
  logic [1:0]         full, full_d;
  logic               fill_bank, launch_bank, fin_q;
  logic [cw-1:0]      count;
  logic               xfer, at_end, close, early;
  logic               launch, fin_evt;
  logic [frame_w-1:0] bank0, bank1;

  assign pix_ready = !full[fill_bank];
  assign xfer      = pix_valid && pix_ready;
  assign at_end    = (count == cw'(npix - 1));
  assign close     = xfer && at_end;
  assign early     = xfer && pix_last && !at_end;

  maxpool_frame_bank #(.npix(npix), .bitwidth(bitwidth)) u_bank0 (
    .clk_en (clk_en),
    .reset_n(reset_n),
    .we     (xfer && !fill_bank),
    .idx    (count),
    .wdata  (pix_data),
    .frame  (bank0)
  );

  maxpool_frame_bank #(.npix(npix), .bitwidth(bitwidth)) u_bank1 (
    .clk_en (clk_en),
    .reset_n(reset_n),
    .we     (xfer && fill_bank),
    .idx    (count),
    .wdata  (pix_data),
    .frame  (bank1)
  );

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    fin_evt = 1'b0;
    case (state)
      IDLE: begin
        if (full[launch_bank]) begin
          launch  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (work_fin && !fin_q) begin
          fin_evt = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Close and release always hit different banks, so both apply on one edge.
  always_comb begin
    full_d = full;
    if (close)   full_d[fill_bank]   = 1'b1;
    if (fin_evt) full_d[launch_bank] = 1'b0;
  end

  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      full        <= '0;
      fill_bank   <= 1'b0;
      launch_bank <= 1'b0;
      count       <= '0;
      fin_q       <= 1'b0;
      work_en     <= 1'b0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      frame_o     <= '0;
    end else begin
      state   <= state_d;
      full    <= full_d;
      work_en <= launch;
      err_len <= (close && !pix_last) || early;
      // Forcing fin_q high on launch masks a stale work_fin left over from the previous frame.
      fin_q   <= launch || work_fin;
      if (xfer) count <= (at_end || pix_last) ? '0 : count + 1'b1;
      if (close) fill_bank <= !fill_bank;
      if (launch) begin
        busy    <= 1'b1;
        frame_o <= launch_bank ? bank1 : bank0;
      end
      if (fin_evt) begin
        busy        <= 1'b0;
        launch_bank <= !launch_bank;
      end
    end
  end

endmodule
